decode_stage_hz: RTL and testbench

Parametrised decode-to-execute stage. It holds an internal register file with write-through bypass from writeback, and detects load-use hazards. When a hazard is found it inserts a bubble and asserts a stall. A branch-taken flush clears the execute slot. It sits between the fetch/decode register and the execute stage. It takes pre-decoded control (CtrlD) and the extended immediate (ImmExtD) from the existing control and sign-extend units.

---
 rtl/decode_stage_hz_if.sv | 48 ++++
 rtl/decode_stage_hz.sv | 108 ++++++++++
 tb/tb_decode_stage_hz.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_hz_if.sv
// Decode/execute boundary bundle: D-side inputs, E-side registered outputs.
interface decode_stage_hz_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned PERF_W = 16
);
  localparam int unsigned AW = $clog2(NREG);

  logic              ValidD;
  logic [31:0]       InstrD;
  logic              UsesRs1D;
  logic              UsesRs2D;
  logic [CTRL_W-1:0] CtrlD;
  logic [XLEN-1:0]   ImmExtD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              RegWriteW;
  logic [AW-1:0]     RDW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;
  logic              StallD;
  logic              ValidE;
  logic [CTRL_W-1:0] CtrlE;
  logic [XLEN-1:0]   RD1_E;
  logic [XLEN-1:0]   RD2_E;
  logic [XLEN-1:0]   ImmExtE;
  logic [AW-1:0]     RS1_E;
  logic [AW-1:0]     RS2_E;
  logic [AW-1:0]     RD_E;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [PERF_W-1:0] StallCount;

  modport master (
    output ValidD, InstrD, UsesRs1D, UsesRs2D, CtrlD, ImmExtD, PCD, PCPlus4D,
    output RegWriteW, RDW, ResultW, FlushE,
    input  StallD, ValidE, CtrlE, RD1_E, RD2_E, ImmExtE, RS1_E, RS2_E, RD_E,
    input  PCE, PCPlus4E, StallCount
  );

  modport slave (
    input  ValidD, InstrD, UsesRs1D, UsesRs2D, CtrlD, ImmExtD, PCD, PCPlus4D,
    input  RegWriteW, RDW, ResultW, FlushE,
    output StallD, ValidE, CtrlE, RD1_E, RD2_E, ImmExtE, RS1_E, RS2_E, RD_E,
    output PCE, PCPlus4E, StallCount
  );
endinterface

// File: rtl/decode_stage_hz.sv
// Decode-to-execute stage: register file with writeback bypass, load-use
// bubble insertion, branch flush of the execute slot and a stall counter.
module decode_stage_hz #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned CTRL_W   = 10,
  parameter int unsigned LOAD_BIT = 0,
  parameter int unsigned PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  decode_stage_hz_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0]   rf_q [NREG];
  logic [AW-1:0]     rs1, rs2, rd;
  logic [XLEN-1:0]   rd1, rd2;
  logic              lu;
  logic              stall;

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [AW-1:0]     rs1_q, rs2_q, rd_q;
  logic [PERF_W-1:0] cnt_q;

  assign rs1 = bus.InstrD[15 +: AW];
  assign rs2 = bus.InstrD[20 +: AW];
  assign rd  = bus.InstrD[7 +: AW];

  // Register file write; x0 is never written so it always reads back zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (bus.RegWriteW && bus.RDW != '0) begin
      rf_q[bus.RDW] <= bus.ResultW;
    end
  end

  // Combinational read with same-cycle bypass from writeback.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) rd1 = (bus.RegWriteW && bus.RDW == rs1) ? bus.ResultW : rf_q[rs1];
    if (rs2 != '0) rd2 = (bus.RegWriteW && bus.RDW == rs2) ? bus.ResultW : rf_q[rs2];
  end

  // Load in E whose non-zero rd is consumed by the instruction in D.
  always_comb begin
    lu = bus.ValidD && valid_q && ctrl_q[LOAD_BIT] && (rd_q != '0) &&
         ((bus.UsesRs1D && rs1 == rd_q) || (bus.UsesRs2D && rs2 == rd_q));
    // A flush squashes the decode instruction upstream, so no hold is needed.
    stall = lu && !bus.FlushE;
  end

  // E register: flush, bubble and empty decode all just invalidate the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (bus.FlushE || lu || !bus.ValidD) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= 1'b1;
      ctrl_q  <= bus.CtrlD;
      rd1_q   <= rd1;
      rd2_q   <= rd2;
      imm_q   <= bus.ImmExtD;
      pc_q    <= bus.PCD;
      pc4_q   <= bus.PCPlus4D;
      rs1_q   <= rs1;
      rs2_q   <= rs2;
      rd_q    <= rd;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (stall && cnt_q != {PERF_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.StallD     = stall;
  assign bus.ValidE     = valid_q;
  assign bus.CtrlE      = ctrl_q;
  assign bus.RD1_E      = rd1_q;
  assign bus.RD2_E      = rd2_q;
  assign bus.ImmExtE    = imm_q;
  assign bus.RS1_E      = rs1_q;
  assign bus.RS2_E      = rs2_q;
  assign bus.RD_E       = rd_q;
  assign bus.PCE        = pc_q;
  assign bus.PCPlus4E   = pc4_q;
  assign bus.StallCount = cnt_q;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Randomised and directed bench for decode_stage_hz against a behavioural model.
module tb_decode_stage_hz;
  localparam int unsigned PW   = 2;
  localparam int unsigned CMAX = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Reference model state
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [9:0]  m_ctrl;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          m_cnt;

  decode_stage_hz_if #(.XLEN(32), .NREG(32), .CTRL_W(10), .PERF_W(PW)) bus ();

  decode_stage_hz #(
    .XLEN(32), .NREG(32), .CTRL_W(10), .LOAD_BIT(0), .PERF_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (bus.RegWriteW && bus.RDW == idx) return bus.ResultW;
    return m_rf[idx];
  endfunction

  function automatic logic m_lu();
    logic [4:0] r1, r2;
    r1 = bus.InstrD[19:15];
    r2 = bus.InstrD[24:20];
    return bus.ValidD && m_valid && m_ctrl[0] && m_rd != 0 &&
           ((bus.UsesRs1D && r1 == m_rd) || (bus.UsesRs2D && r2 == m_rd));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pc4 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0;
  endtask

  // Advance the model over one clock edge, then the DUT; leave time at edge+1.
  task automatic tick();
    logic lu;
    lu = m_lu();
    if (bus.FlushE || lu || !bus.ValidD) begin
      m_valid = 0;
      m_ctrl  = 0;
    end else begin
      m_valid = 1;
      m_ctrl  = bus.CtrlD;
      m_rd1   = m_read(bus.InstrD[19:15]);
      m_rd2   = m_read(bus.InstrD[24:20]);
      m_imm   = bus.ImmExtD;
      m_pc    = bus.PCD;
      m_pc4   = bus.PCPlus4D;
      m_rs1   = bus.InstrD[19:15];
      m_rs2   = bus.InstrD[24:20];
      m_rd    = bus.InstrD[11:7];
    end
    if (lu && !bus.FlushE && m_cnt < CMAX) m_cnt++;
    if (bus.RegWriteW && bus.RDW != 0) m_rf[bus.RDW] = bus.ResultW;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdx, input logic u1, input logic u2,
                       input logic [9:0] ctrl);
    bus.ValidD   = v;
    bus.InstrD   = {7'h0, r2, r1, 3'h0, rdx, 7'h33};
    bus.UsesRs1D = u1;
    bus.UsesRs2D = u2;
    bus.CtrlD    = ctrl;
    bus.ImmExtD  = $urandom;
    bus.PCD      = $urandom;
    bus.PCPlus4D = bus.PCD + 32'd4;
  endtask

  task automatic quiet_wb();
    bus.RegWriteW = 0;
    bus.RDW       = 0;
    bus.ResultW   = 0;
    bus.FlushE    = 0;
  endtask

  task automatic apply_reset();
    rst = 0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic test_reset();
    quiet_wb();
    drive(1, 5'd1, 5'd2, 5'd3, 1, 1, 10'h3f2);
    tick();
    n_checks++;
    if (bus.ValidE !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_valid: got %b want 1", bus.ValidE);
    end
    #2;
    rst = 0;
    #1;
    model_reset();
    n_checks++;
    if (bus.ValidE !== 1'b0 || bus.CtrlE !== 10'h0 || bus.PCE !== 32'h0 ||
        bus.RD_E !== 5'h0 || bus.ImmExtE !== 32'h0 || bus.StallCount !== 2'd0 ||
        bus.StallD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b c=%h pc=%h rd=%h imm=%h cnt=%0d st=%b want all 0",
               bus.ValidE, bus.CtrlE, bus.PCE, bus.RD_E, bus.ImmExtE, bus.StallCount,
               bus.StallD);
    end
    @(posedge clk);
    #1;
    rst = 1;
    drive(1, 5'd5, 5'd0, 5'd1, 1, 0, 10'h002);
    tick();
    n_checks++;
    if (bus.RD1_E !== 32'h0 || bus.ValidE !== 1'b1) begin
      n_fail++; $display("FAIL reset_read_x5: got %h v=%b want 0 v=1", bus.RD1_E, bus.ValidE);
    end
  endtask

  task automatic test_bypass();
    bus.RegWriteW = 1; bus.RDW = 5'd3; bus.ResultW = 32'hDEADBEEF;
    drive(1, 5'd3, 5'd0, 5'd4, 1, 0, 10'h002);
    tick();
    n_checks++;
    if (bus.RD1_E !== 32'hDEADBEEF || bus.ValidE !== 1'b1) begin
      n_fail++; $display("FAIL bypass_rd1: got %h v=%b want deadbeef v=1", bus.RD1_E, bus.ValidE);
    end
    bus.RDW = 5'd0; bus.ResultW = 32'h1234;
    drive(1, 5'd0, 5'd3, 5'd4, 1, 1, 10'h002);
    tick();
    n_checks++;
    if (bus.RD1_E !== 32'h0 || bus.RD2_E !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_x0_same: got rd1=%h rd2=%h want 0 deadbeef", bus.RD1_E, bus.RD2_E);
    end
    quiet_wb();
    drive(1, 5'd3, 5'd0, 5'd4, 1, 1, 10'h002);
    tick();
    n_checks++;
    if (bus.RD1_E !== 32'hDEADBEEF || bus.RD2_E !== 32'h0) begin
      n_fail++; $display("FAIL rf_x0_read: got rd1=%h rd2=%h want deadbeef 0", bus.RD1_E, bus.RD2_E);
    end
  endtask

  task automatic test_load_use();
    int c0;
    quiet_wb();
    c0 = m_cnt;
    drive(1, 5'd1, 5'd2, 5'd7, 1, 1, 10'h081);
    tick();
    n_checks++;
    if (bus.ValidE !== 1'b1 || bus.CtrlE[0] !== 1'b1 || bus.RD_E !== 5'd7) begin
      n_fail++; $display("FAIL lu_load_cap: got v=%b c=%h rd=%0d want 1 load 7", bus.ValidE, bus.CtrlE, bus.RD_E);
    end
    drive(1, 5'd2, 5'd7, 5'd8, 1, 1, 10'h002);
    #1;
    n_checks++;
    if (bus.StallD !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall: got %b want 1", bus.StallD);
    end
    tick();
    n_checks++;
    if (bus.ValidE !== 1'b0 || bus.CtrlE !== 10'h0 || bus.StallCount !== 2'(c0 + 1)) begin
      n_fail++; $display("FAIL lu_bubble: got v=%b c=%h cnt=%0d want 0 0 %0d", bus.ValidE, bus.CtrlE,
                         bus.StallCount, c0 + 1);
    end
    n_checks++;
    if (bus.StallD !== 1'b0) begin
      n_fail++; $display("FAIL lu_stall_drop: got %b want 0", bus.StallD);
    end
    tick();
    n_checks++;
    if (bus.ValidE !== 1'b1 || bus.RD_E !== 5'd8 || bus.RS2_E !== 5'd7 || bus.CtrlE !== 10'h002) begin
      n_fail++; $display("FAIL lu_replay: got v=%b rd=%0d rs2=%0d c=%h want 1 8 7 002", bus.ValidE,
                         bus.RD_E, bus.RS2_E, bus.CtrlE);
    end
  endtask

  task automatic test_no_false_stall();
    quiet_wb();
    drive(1, 5'd1, 5'd2, 5'd7, 1, 1, 10'h001);
    tick();
    drive(1, 5'd7, 5'd4, 5'd9, 0, 1, 10'h002);
    #1;
    n_checks++;
    if (bus.StallD !== 1'b0) begin
      n_fail++; $display("FAIL nfs_unused_rs1: got %b want 0", bus.StallD);
    end
    tick();
    n_checks++;
    if (bus.ValidE !== 1'b1 || bus.RD_E !== 5'd9) begin
      n_fail++; $display("FAIL nfs_capture: got v=%b rd=%0d want 1 9", bus.ValidE, bus.RD_E);
    end
    drive(1, 5'd1, 5'd2, 5'd0, 1, 1, 10'h001);
    tick();
    drive(1, 5'd0, 5'd0, 5'd10, 1, 1, 10'h002);
    #1;
    n_checks++;
    if (bus.StallD !== 1'b0) begin
      n_fail++; $display("FAIL nfs_x0: got %b want 0", bus.StallD);
    end
    tick();
    n_checks++;
    if (bus.ValidE !== 1'b1 || bus.RD_E !== 5'd10) begin
      n_fail++; $display("FAIL nfs_x0_cap: got v=%b rd=%0d want 1 10", bus.ValidE, bus.RD_E);
    end
  endtask

  task automatic test_flush();
    int c0;
    quiet_wb();
    drive(1, 5'd1, 5'd2, 5'd9, 1, 1, 10'h001);
    tick();
    c0 = m_cnt;
    drive(1, 5'd9, 5'd0, 5'd11, 1, 0, 10'h002);
    bus.FlushE = 1;
    #1;
    n_checks++;
    if (bus.StallD !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b want 0", bus.StallD);
    end
    tick();
    bus.FlushE = 0;
    n_checks++;
    if (bus.ValidE !== 1'b0 || bus.CtrlE !== 10'h0 || bus.StallCount !== 2'(c0)) begin
      n_fail++; $display("FAIL flush_kill: got v=%b c=%h cnt=%0d want 0 0 %0d", bus.ValidE, bus.CtrlE,
                         bus.StallCount, c0);
    end
  endtask

  task automatic test_saturation();
    quiet_wb();
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 5'd1, 5'd2, 5'd6, 1, 1, 10'h001);
      tick();
      drive(1, 5'd6, 5'd3, 5'd12, 1, 0, 10'h002);
      tick();
      tick();
      n_checks++;
      if (bus.StallCount !== 2'((k > 3) ? 3 : k) || bus.ValidE !== 1'b1) begin
        n_fail++; $display("FAIL sat_%0d: got cnt=%0d v=%b want %0d 1", k, bus.StallCount, bus.ValidE,
                           (k > 3) ? 3 : k);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 10'($urandom));
      bus.RegWriteW = 1'($urandom);
      bus.RDW       = 5'($urandom_range(0, 7));
      bus.ResultW   = $urandom;
      bus.FlushE    = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++;
      if (bus.StallD !== (m_lu() && !bus.FlushE)) begin
        n_fail++; bad++;
        $display("FAIL rnd_stall_%0d: got %b want %b", n, bus.StallD, m_lu() && !bus.FlushE);
      end
      tick();
      n_checks++;
      if (bus.ValidE !== m_valid || bus.CtrlE !== m_ctrl || bus.StallCount !== 2'(m_cnt) ||
          (m_valid && (bus.RD1_E !== m_rd1 || bus.RD2_E !== m_rd2 || bus.ImmExtE !== m_imm ||
                       bus.PCE !== m_pc || bus.PCPlus4E !== m_pc4 || bus.RS1_E !== m_rs1 ||
                       bus.RS2_E !== m_rs2 || bus.RD_E !== m_rd))) begin
        n_fail++; bad++;
        $display("FAIL rnd_e_%0d: got v=%b c=%h cnt=%0d rd1=%h rd2=%h want v=%b c=%h cnt=%0d rd1=%h rd2=%h",
                 n, bus.ValidE, bus.CtrlE, bus.StallCount, bus.RD1_E, bus.RD2_E,
                 m_valid, m_ctrl, m_cnt, m_rd1, m_rd2);
      end
      if (bad > 10) break;
    end
    quiet_wb();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    quiet_wb();
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 10'h0);
    apply_reset();
    test_reset();
    test_bypass();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_saturation();
    apply_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
